traffic_request_conditioner: RTL and testbench

Upstream front-end for the 4-way traffic controller. It takes the four raw push-button/sensor request inputs, synchronises and debounces them, and holds each accepted request in a sticky latch until the controller reports that direction as served. It drives the controller's per-direction request vector and keeps a saturating count of accepted requests for debug readout.

---
 rtl/traffic_request_conditioner.sv | 102 ++++++++++
 tb/tb_traffic_request_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_conditioner.sv
// Request front-end for the 4-way traffic controller: synchronises and debounces the raw
// request inputs, latches accepted presses until served, and counts accepted presses.
module traffic_request_conditioner #(
  parameter int unsigned      CNT_W           = 24,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 24'd100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] btn_in,
  input  logic       serve_valid,
  input  logic [1:0] serve_dir,
  output logic [3:0] req_out,
  output logic [3:0] req_pulse,
  output logic [3:0] db_state,
  output logic [7:0] event_count
);

  localparam logic [CNT_W-1:0] CntMax = DEBOUNCE_CYCLES - CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       db_q, db_d;
  logic [3:0]       req_q, req_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [7:0]       ev_q, ev_d;
  logic [3:0]       rise;
  logic [2:0]       n_rise;
  logic [8:0]       ev_sum;

  // Synchroniser keeps running while the block is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    req_d   = req_q;
    ev_d    = ev_q;
    rise    = '0;
    n_rise  = '0;
    ev_sum  = {1'b0, ev_q};
    if (ena) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_d[i] = '0;
          db_d[i]  = sync2_q[i];
          rise[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (serve_valid) begin
        req_d[serve_dir] = 1'b0;
      end
      // A press committing on the serve edge is a fresh request, so set beats clear.
      req_d = req_d | rise;
      for (int i = 0; i < 4; i++) begin
        n_rise = n_rise + {2'b00, rise[i]};
      end
      ev_sum = {1'b0, ev_q} + {6'b000000, n_rise};
      ev_d   = ev_sum[8] ? 8'hFF : ev_sum[7:0];
    end
    pulse_d = rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      db_q    <= '0;
      req_q   <= '0;
      pulse_q <= '0;
      ev_q    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      db_q    <= db_d;
      req_q   <= req_d;
      pulse_q <= pulse_d;
      ev_q    <= ev_d;
    end
  end

  assign req_out     = req_q;
  assign req_pulse   = pulse_q;
  assign db_state    = db_q;
  assign event_count = ev_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Bench for traffic_request_conditioner: cycle table, directed corner sequences and random
// stimulus, all compared against a sample-history reference model.
module tb_traffic_request_conditioner;

  localparam int unsigned D = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_in;
  logic       serve_valid;
  logic [1:0] serve_dir;
  logic [3:0] req_out;
  logic [3:0] req_pulse;
  logic [3:0] db_state;
  logic [7:0] event_count;

  traffic_request_conditioner #(
    .CNT_W          (4),
    .DEBOUNCE_CYCLES(4'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_in     (btn_in),
    .serve_valid(serve_valid),
    .serve_dir  (serve_dir),
    .req_out    (req_out),
    .req_pulse  (req_pulse),
    .db_state   (db_state),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: input delayed two edges, then a commit happens when the last D
  // active-cycle samples all disagree with the debounced level.
  logic [3:0] m_sync1, m_sync2, m_db, m_req, m_pulse;
  int         m_ev;
  bit         m_log [4][$];

  typedef struct {
    logic [3:0] btn;
    logic       sv;
    logic [1:0] sd;
    logic [3:0] req;
    logic [3:0] pulse;
    logic [3:0] db;
    logic [7:0] ev;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_sync1 = '0;
    m_sync2 = '0;
    m_db    = '0;
    m_req   = '0;
    m_pulse = '0;
    m_ev    = 0;
    for (int i = 0; i < 4; i++) m_log[i].delete();
  endtask

  task automatic model_edge(input logic [3:0] b, input logic v, input logic [1:0] d,
                            input logic e);
    logic [3:0] s_now;
    logic [3:0] rise;
    bit         all_diff;
    s_now   = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = b;
    rise    = '0;
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        m_log[i].push_back(s_now[i]);
        if (m_log[i].size() > D) void'(m_log[i].pop_front());
        all_diff = (m_log[i].size() == D);
        foreach (m_log[i][j]) if (m_log[i][j] == m_db[i]) all_diff = 0;
        if (all_diff) begin
          rise[i] = ~m_db[i];
          m_db[i] = ~m_db[i];
        end
      end
      if (v) m_req[d] = 1'b0;
      m_req = m_req | rise;
      m_ev  = m_ev + $countones(rise);
      if (m_ev > 255) m_ev = 255;
    end
    m_pulse = rise;
  endtask

  // Drive at the falling edge, let one rising edge happen, compare at the next falling edge.
  task automatic cyc(input logic [3:0] b, input logic v, input logic [1:0] d, input logic e);
    btn_in      = b;
    serve_valid = v;
    serve_dir   = d;
    ena         = e;
    @(posedge clk);
    model_edge(b, v, d, e);
    @(negedge clk);
    check("req_out", req_out, m_req);
    check("req_pulse", req_pulse, m_pulse);
    check("db_state", db_state, m_db);
    check("event_count", event_count, m_ev);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_out", req_out, 0);
    check("rst_req_pulse", req_pulse, 0);
    check("rst_db_state", db_state, 0);
    check("rst_event_count", event_count, 0);
    model_reset();
    btn_in      = '0;
    serve_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] cur_btn;
  logic [3:0] held_req;
  int         ev_before;

  initial begin
    rst_n       = 1'b0;
    ena         = 1'b1;
    btn_in      = '0;
    serve_valid = 1'b0;
    serve_dir   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_req_out", req_out, 0);
    check("init_event_count", event_count, 0);
    rst_n = 1'b1;

    // Clean press on bit 2, release, then serve.
    for (int r = 0; r < 5; r++) tbl[r] = '{4'b0100, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 8'd0};
    tbl[5] = '{4'b0100, 1'b0, 2'd0, 4'b0100, 4'b0100, 4'b0100, 8'd1};
    tbl[6] = '{4'b0100, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0100, 8'd1};
    for (int r = 7; r < 12; r++) tbl[r] = '{4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0100, 8'd1};
    tbl[12] = '{4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0000, 8'd1};
    tbl[13] = '{4'b0000, 1'b1, 2'd3, 4'b0100, 4'b0000, 4'b0000, 8'd1};
    tbl[14] = '{4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000, 4'b0000, 8'd1};
    for (int r = 0; r < 15; r++) begin
      cyc(tbl[r].btn, tbl[r].sv, tbl[r].sd, 1'b1);
      check("tbl_req", req_out, tbl[r].req);
      check("tbl_pulse", req_pulse, tbl[r].pulse);
      check("tbl_db", db_state, tbl[r].db);
      check("tbl_ev", event_count, tbl[r].ev);
    end

    // Build req_out = 0011, serve bit 0, then serve a bit that is not pending.
    repeat (6) cyc(4'b0011, 1'b0, 2'd0, 1'b1);
    repeat (6) cyc(4'b0000, 1'b0, 2'd0, 1'b1);
    check("pre_serve", req_out, 4'b0011);
    cyc(4'b0000, 1'b1, 2'd0, 1'b1);
    check("serve_dir0", req_out, 4'b0010);
    cyc(4'b0000, 1'b1, 2'd3, 1'b1);
    check("serve_not_pending", req_out, 4'b0010);

    // Rising commit on bit 1 on the same edge as its serve.
    for (int k = 0; k < 6; k++) cyc(4'b0010, (k == 5), 2'd1, 1'b1);
    check("collide_req1", req_out[1], 1'b1);
    check("collide_pulse1", req_pulse[1], 1'b1);
    // Serve while still held: clears and does not re-request.
    cyc(4'b0010, 1'b1, 2'd1, 1'b1);
    repeat (6) cyc(4'b0010, 1'b0, 2'd0, 1'b1);
    check("held_no_rereq", req_out[1], 1'b0);
    repeat (6) cyc(4'b0000, 1'b0, 2'd0, 1'b1);
    repeat (6) cyc(4'b1010, 1'b0, 2'd0, 1'b1);
    check("pre_reset_req", req_out, 4'b1010);

    // Asynchronous reset with requests pending.
    do_reset();
    repeat (3) cyc(4'b0000, 1'b0, 2'd0, 1'b1);

    // Bounce: 3 high, 1 low, 3 high must not commit.
    repeat (3) cyc(4'b0001, 1'b0, 2'd0, 1'b1);
    cyc(4'b0000, 1'b0, 2'd0, 1'b1);
    repeat (3) cyc(4'b0001, 1'b0, 2'd0, 1'b1);
    repeat (6) cyc(4'b0000, 1'b0, 2'd0, 1'b1);
    check("bounce_req", req_out, 4'b0000);
    check("bounce_ev", event_count, 0);
    repeat (6) cyc(4'b0001, 1'b0, 2'd0, 1'b1);
    check("bounce_commit_req", req_out, 4'b0001);
    check("bounce_commit_ev", event_count, 1);
    repeat (6) cyc(4'b0000, 1'b0, 2'd0, 1'b1);

    // Saturation: 64 presses of all four bits.
    for (int p = 0; p < 64; p++) begin
      repeat (6) cyc(4'b1111, 1'b0, 2'd0, 1'b1);
      repeat (6) cyc(4'b0000, 1'b0, 2'd0, 1'b1);
    end
    check("saturate_ev", event_count, 255);

    // Frozen block: presses and serves are ignored.
    held_req  = req_out;
    ev_before = event_count;
    for (int k = 0; k < 10; k++) begin
      cyc(4'b1000, (k == 3), 2'd0, 1'b0);
      check("frozen_pulse", req_pulse, 4'b0000);
      check("frozen_req", req_out, held_req);
    end
    check("frozen_ev", event_count, ev_before);
    repeat (8) cyc(4'b0000, 1'b1, 2'd3, 1'b1);

    // Random traffic against the model.
    do_reset();
    cur_btn = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) cur_btn[i] = ~cur_btn[i];
      end
      cyc(cur_btn, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
